systolic_skew_feeder: RTL and testbench
=======================================

# systolic_skew_feeder

Input staging stage for the systolic array datapath: accepts packed vectors of `size` lanes through a valid/ready handshake, buffers them in a small FIFO, and launches them diagonally skewed, so lane i arrives i cycles after lane 0. It sits directly upstream of the per-lane register delay lines and the PE array. It also supplies per-lane valid flags, a stall input, and an end-of-batch pulse.

## Interface
- `data_size`, 16, bits per lane element
- `size`, 4, number of lanes (≥1)
- `depth`, 4, FIFO entries (≥2)

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `in_data`  input  data_size*size  packed vector; lane i at bits [data_size*(i+1)-1 : data_size*i]
- `in_valid`  input  1  producer has a vector
- `in_last`  input  1  vector is the last of a batch; sampled with the push
- `in_ready`  output  1  FIFO can accept a vector
- `en`  input  1  array advance; low = stall the whole skew pipeline
- `out_data`  output  data_size*size  skewed packed output
- `out_valid`  output  size  per-lane valid
- `done`  output  1  one-cycle pulse: the last vector of the batch has left lane size-1
- `busy`  output  1  FIFO or skew pipeline holds valid data

## Operation
- Clock and reset are as listed in Interface: one clock `clk`; `rst_n` is asynchronous and active-low.
- FIFO
  - Each entry holds `{last, data}`. Count width is $clog2(depth+1).
  - Push when `in_valid && in_ready`.
  - Pop when `en && count != 0`.
  - Push and pop may happen on the same edge; count is then unchanged.
  - `in_ready = (count != depth)`. It is registered-state-derived only, with no combinational path from `en`. When the FIFO is full, nothing is accepted, even if a pop happens on that edge.
  - Read/write pointers wrap modulo `depth`. Non-power-of-2 `depth` must be supported.
- Skew pipeline
  - Lane i has a chain of i+1 registers carrying `{valid, last, data}`.
  - On an edge with `en=1`:
    - stage 0 of every lane loads the popped entry with valid=1, or a bubble (valid=0, last=0, data=0) when the FIFO is empty;
    - every deeper stage shifts one place.
  - On an edge with `en=0`, all skew registers hold and there is no pop.
  - `out_data` lane i and `out_valid[i]` come from the final register of lane i's chain.
- `done` is registered. It is high for exactly the one cycle in which lane size-1 presents a vector with last=1 and `out_valid[size-1]=1`. While stalled, it is high for one cycle only, not held.
- `busy = (count != 0) | (OR of all skew-register valid bits)`.
- Status (no explicit FSM register needed):
  - IDLE: busy=0;
  - RUN: count != 0;
  - DRAIN: count == 0 but the pipeline still holds valid data.
- `size=1` degenerates to a FIFO plus one output register.

## Timing
- Reset (asynchronous, immediate, also mid-operation):
  - FIFO emptied and pointers zeroed;
  - all skew registers cleared;
  - `out_data=0`, `out_valid=0`, `done=0`, `busy=0`, `in_ready=1`.
- Vectors are popped in push order.
- Latency, for a vector popped at edge k:
  - lane 0 is valid after edge k;
  - lane i is valid after the i-th subsequent `en=1` edge;
  - with `en` held high, lane i appears after edge k+i.
- Minimum push-to-lane-0 latency is 2 edges: push at edge p, pop at edge p+1 if `en=1`.
- Throughput is one vector per cycle with `en` held high and `in_valid` continuous.
- Stall: outputs stay constant while `en=0`; the FIFO may still fill up to `depth`.
- Back-to-back batches: `in_last` only tags a vector. The next batch may follow with no gap, and there is one `done` per tagged vector.

## Test plan
- Reset then idle: `rst_n` low, then high with `en=1` and no input. Required: `in_ready=1`, `out_valid=4'b0000`, `busy=0`, `done=0` for 10 cycles.
- Skew check: push V0 = {lane3..0}={0x0004,0x0003,0x0002,0x0001} with in_last=1, `en=1`. Required:
  - lane 0 = 0x0001 with out_valid=0001 two edges after the push;
  - lane 1 = 0x0002 one edge later, then lane 2, then lane 3;
  - `done` high for exactly one cycle, together with lane 3 = 0x0004;
  - `busy` low on the following cycle.
- Streaming: 8 consecutive pushes of 0x10..0x17 in every lane, `en=1`. Required: lane 0 shows 0x10..0x17 on consecutive cycles; lane 3 shows the same sequence 3 cycles later; no bubbles; `in_ready` never drops.
- Full/stall: `en=0`, push 5 vectors. Required: only 4 are accepted and `in_ready=0` after the 4th. Raising `en` pops one per cycle, `in_ready` returns high after the first pop, and data order is preserved.
- Mid-stream stall: during streaming, drop `en` for 3 cycles. Required: all outputs frozen for those cycles, then the sequence resumes with no loss or duplication.
- Reset mid-operation: assert `rst_n` low with 3 vectors in the FIFO and the pipeline full. Required: all outputs go to their reset values immediately (asynchronously), and no stale data appears after release.

Source files
------------

// File: rtl/systolic_skew_feeder_if.sv
// Bundle for the skew feeder: producer-side handshake, array advance and the
// skewed lane outputs. The master drives stimulus; the feeder is the slave.
interface systolic_skew_feeder_if #(
   parameter int data_size = 16,
   parameter int size      = 4
);
   logic [data_size*size-1:0] in_data;
   logic                      in_valid;
   logic                      in_last;
   logic                      in_ready;
   logic                      en;
   logic [data_size*size-1:0] out_data;
   logic [size-1:0]           out_valid;
   logic                      done;
   logic                      busy;

   modport master (
      output in_data, in_valid, in_last, en,
      input  in_ready, out_data, out_valid, done, busy
   );

   modport slave (
      input  in_data, in_valid, in_last, en,
      output in_ready, out_data, out_valid, done, busy
   );
endinterface

// File: rtl/systolic_skew_feeder.sv
// FIFO-buffered input stage for the systolic array: each popped vector is launched
// diagonally so that lane i trails lane 0 by i advancing (en=1) cycles.
module systolic_skew_feeder #(
   parameter int data_size = 16,
   parameter int size      = 4,
   parameter int depth     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   systolic_skew_feeder_if.slave bus
);
   localparam int VW = data_size * size;
   localparam int EW = VW + 1;
   localparam int CW = $clog2(depth + 1);
   localparam int PW = (depth > 1) ? $clog2(depth) : 1;
   localparam int SW = data_size + 2;

   logic [EW-1:0]   mem_q [depth];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            done_q, done_d;
   logic            full;
   logic            push;
   logic            pop;
   logic [EW-1:0]   head;
   logic [size-1:0] lane_busy;
   logic            tail_valid;
   logic            tail_last;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
   endfunction

   // in_ready depends on the stored count only, so a full FIFO refuses a push
   // even on an edge that also pops.
   assign full = (count_q == CW'(depth));
   assign push = bus.in_valid && !full;
   assign pop  = bus.en && (count_q != '0);
   assign head = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {bus.in_last, bus.in_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   for (genvar gi = 0; gi < size; gi++) begin : g_lane
      logic [SW-1:0] chain_q [gi+1];
      logic [SW-1:0] stage_in;
      logic          any_valid;

      always_comb begin
         stage_in = '0;
         if (pop) begin
            stage_in = {1'b1, head[EW-1], head[data_size*gi +: data_size]};
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int s = 0; s <= gi; s++) begin
               chain_q[s] <= '0;
            end
         end else if (bus.en) begin
            chain_q[0] <= stage_in;
            for (int s = 1; s <= gi; s++) begin
               chain_q[s] <= chain_q[s-1];
            end
         end
      end

      always_comb begin
         any_valid = 1'b0;
         for (int s = 0; s <= gi; s++) begin
            any_valid = any_valid | chain_q[s][SW-1];
         end
      end

      assign lane_busy[gi]                           = any_valid;
      assign bus.out_data[data_size*gi +: data_size] = chain_q[gi][data_size-1:0];
      assign bus.out_valid[gi]                       = chain_q[gi][SW-1];

      // What the last lane's output register will take on the next advancing edge.
      if (gi == size - 1) begin : g_tail
         if (gi == 0) begin : g_direct
            assign tail_valid = stage_in[SW-1];
            assign tail_last  = stage_in[SW-2];
         end else begin : g_shift
            assign tail_valid = chain_q[gi-1][SW-1];
            assign tail_last  = chain_q[gi-1][SW-2];
         end
      end
   end

   // Only an advancing edge can bring a new tagged vector onto the last lane,
   // so a stall never stretches the pulse.
   assign done_d = bus.en && tail_valid && tail_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   assign bus.in_ready = !full;
   assign bus.done     = done_q;
   assign bus.busy     = (count_q != '0) | (|lane_busy);
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (16-bit lanes, 4 lanes, 4-entry FIFO):
// reset, skew, streaming, full/stall, mid-stream stall and mid-operation reset.
module tb_systolic_skew_feeder;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int D  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.data_size(DW), .size(N)) bus ();

    systolic_skew_feeder #(.data_size(DW), .size(N), .depth(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] splat(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    // Expected lanes after e advancing edges: item j sits on lane i when
    // j = e - e0 - i, with value base + j + lstep*i.
    task automatic chk_out(input string tag, input int e, input int e0, input int base,
                           input int lstep, input int n, input int last_j, input bit moved);
        logic [63:0] ed;
        logic [3:0]  ev;
        logic        edn;
        int          j;
        ed  = '0;
        ev  = '0;
        edn = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = e - e0 - i;
            if (j >= 0 && j < n) begin
                ev[i] = 1'b1;
                ed[16*i +: 16] = 16'(base + j + lstep * i);
                if (i == N - 1 && j == last_j && moved) edn = 1'b1;
            end
        end
        check({tag, ".valid"}, 64'(bus.out_valid), 64'(ev));
        check({tag, ".data"},  bus.out_data, ed);
        check({tag, ".done"},  64'(bus.done), 64'(edn));
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".flags"}, 64'({bus.in_ready, bus.out_valid, bus.busy, bus.done}), 64'(7'b1000000));
        check({tag, ".data"},  bus.out_data, 64'h0);
    endtask

    initial begin
        int e;
        int item;
        bit en_c;
        bit rdy_c;

        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.en       = 1'b1;

        // reset then idle
        rst_n = 1'b0;
        repeat (2) tick();
        chk_idle("rst");
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_idle("idle");
        end

        // single tagged vector, distinct lane values
        e = 0;
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        tick(); e++;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        check("skew.busy1", 64'(bus.busy), 64'(1));
        chk_out("skew", e, 2, 1, 1, 1, 0, 1'b1);
        for (int c = 1; c < 6; c++) begin
            tick(); e++;
            chk_out("skew", e, 2, 1, 1, 1, 0, 1'b1);
        end
        check("skew.busy_end", 64'(bus.busy), 64'(0));

        // streaming 0x10..0x17, last tag on 0x17
        e = 0;
        for (int c = 0; c < 13; c++) begin
            bus.in_valid = (c < 8);
            bus.in_last  = (c == 7);
            bus.in_data  = splat(16'(16'h10 + c));
            check("stream.ready", 64'(bus.in_ready), 64'(1));
            tick(); e++;
            chk_out("stream", e, 2, 'h10, 0, 8, 7, 1'b1);
            check("stream.busy", 64'(bus.busy), 64'(c <= 11));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        // full while stalled: five offered, four accepted
        bus.en = 1'b0;
        e = 0;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_last  = (k == 3);
            bus.in_data  = splat(16'(16'h20 + k));
            check("full.ready", 64'(bus.in_ready), 64'(k < 4));
            tick();
            chk_out("full.stall", e, 1, 'h20, 0, 4, 3, 1'b0);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("full.ready4", 64'(bus.in_ready), 64'(0));
        check("full.busy", 64'(bus.busy), 64'(1));
        bus.en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick(); e++;
            if (c == 0) check("full.ready_back", 64'(bus.in_ready), 64'(1));
            chk_out("full.drain", e, 1, 'h20, 0, 4, 3, 1'b1);
        end
        check("full.busy_end", 64'(bus.busy), 64'(0));

        // streaming with en low on edges 4..6
        e = 0;
        item = 0;
        for (int c = 0; c < 17; c++) begin
            en_c  = !(c >= 4 && c <= 6);
            rdy_c = (c != 7);
            bus.en       = en_c;
            bus.in_valid = (item < 8);
            bus.in_last  = (item == 7);
            bus.in_data  = splat(16'(16'h30 + item));
            check("stall.ready", 64'(bus.in_ready), 64'(rdy_c));
            if (item < 8 && rdy_c) item++;
            tick();
            if (en_c) e++;
            chk_out("stall", e, 2, 'h30, 0, 8, 7, en_c);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.en       = 1'b1;
        check("stall.busy_end", 64'(bus.busy), 64'(0));

        // fill pipeline, leave three entries queued, then reset asynchronously
        e = 0;
        for (int c = 0; c < 9; c++) begin
            bus.en       = (c < 7);
            bus.in_valid = 1'b1;
            bus.in_data  = splat(16'(16'h40 + c));
            tick();
            if (c < 7) e++;
        end
        bus.in_valid = 1'b0;
        chk_out("prerst", e, 2, 'h40, 0, 9, -1, 1'b0);
        check("prerst.busy", 64'(bus.busy), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        bus.en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk_idle("post_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
